// File: rtl/pm_video_pkg.sv
// Shared video definitions: default raster timing and the per-pixel output record.
package pm_video_pkg;

    localparam int unsigned H_ACTIVE = 96;
    localparam int unsigned H_FP     = 8;
    localparam int unsigned H_SYNC   = 8;
    localparam int unsigned H_BP     = 16;
    localparam int unsigned V_ACTIVE = 64;
    localparam int unsigned V_FP     = 4;
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BP     = 8;
    localparam logic [7:0]  OFF_LEVEL = 8'hD0;

    typedef struct packed {
        logic [7:0] luma;
        logic       de;
        logic       hsync;
        logic       vsync;
        logic       hblank;
        logic       vblank;
    } pixel_t;

endpackage

// File: rtl/pm_video_timing.sv
// Raster position counters advancing on a clock enable, with sync/blank/active decode
// of both the current and the upcoming position.
module pm_video_timing #(
    parameter int unsigned H_ACTIVE = pm_video_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = pm_video_pkg::H_FP,
    parameter int unsigned H_SYNC   = pm_video_pkg::H_SYNC,
    parameter int unsigned H_BP     = pm_video_pkg::H_BP,
    parameter int unsigned V_ACTIVE = pm_video_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = pm_video_pkg::V_FP,
    parameter int unsigned V_SYNC   = pm_video_pkg::V_SYNC,
    parameter int unsigned V_BP     = pm_video_pkg::V_BP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic [7:0] h,
    output logic [6:0] v,
    output logic [7:0] h_next,
    output logic [6:0] v_next,
    output logic       active,
    output logic       next_active,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank
);

    localparam logic [7:0] H_ACT     = 8'(H_ACTIVE);
    localparam logic [7:0] H_SYNC_LO = 8'(H_ACTIVE + H_FP);
    localparam logic [7:0] H_SYNC_HI = 8'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [7:0] H_LAST    = 8'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [6:0] V_ACT     = 7'(V_ACTIVE);
    localparam logic [6:0] V_SYNC_LO = 7'(V_ACTIVE + V_FP);
    localparam logic [6:0] V_SYNC_HI = 7'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [6:0] V_LAST    = 7'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    always_comb begin
        h_next = h + 8'd1;
        v_next = v;
        if (h == H_LAST) begin
            h_next = '0;
            v_next = (v == V_LAST) ? '0 : v + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (ce) begin
            h <= h_next;
            v <= v_next;
        end
    end

    assign active      = (h < H_ACT) && (v < V_ACT);
    assign next_active = (h_next < H_ACT) && (v_next < V_ACT);
    assign hsync       = (h >= H_SYNC_LO) && (h < H_SYNC_HI);
    assign vsync       = (v >= V_SYNC_LO) && (v < V_SYNC_HI);
    assign hblank      = (h >= H_ACT);
    assign vblank      = (v >= V_ACT);

endmodule

// File: rtl/lcd_scanout.sv
// Scans the LCD controller's page-organised display RAM out as a raster grey-level
// pixel stream, one pixel per ce_pix, one pixel behind the position counters.
module lcd_scanout #(
    parameter int unsigned H_ACTIVE  = pm_video_pkg::H_ACTIVE,
    parameter int unsigned H_FP      = pm_video_pkg::H_FP,
    parameter int unsigned H_SYNC    = pm_video_pkg::H_SYNC,
    parameter int unsigned H_BP      = pm_video_pkg::H_BP,
    parameter int unsigned V_ACTIVE  = pm_video_pkg::V_ACTIVE,
    parameter int unsigned V_FP      = pm_video_pkg::V_FP,
    parameter int unsigned V_SYNC    = pm_video_pkg::V_SYNC,
    parameter int unsigned V_BP      = pm_video_pkg::V_BP,
    parameter logic [7:0]  OFF_LEVEL = pm_video_pkg::OFF_LEVEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [5:0] lcd_contrast,
    output logic [7:0] read_x,
    output logic [3:0] read_y,
    input  logic [7:0] read_column,
    output logic [7:0] luma,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       frame_start
);

    import pm_video_pkg::*;

    logic [7:0] h, h_next;
    logic [6:0] v, v_next;
    logic       active, next_active;
    logic       t_hsync, t_vsync, t_hblank, t_vblank;
    logic [8:0] on_diff;
    logic [7:0] on_level;
    pixel_t     pix_next, pix_q;
    logic       frame_start_q;

    pm_video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce_pix),
        .h           (h),
        .v           (v),
        .h_next      (h_next),
        .v_next      (v_next),
        .active      (active),
        .next_active (next_active),
        .hsync       (t_hsync),
        .vsync       (t_vsync),
        .hblank      (t_hblank),
        .vblank      (t_vblank)
    );

    // Address the pixel the counters move to, so its byte is ready by the next ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_x <= '0;
            read_y <= '0;
        end else if (ce_pix) begin
            read_x <= next_active ? h_next : '0;
            read_y <= next_active ? 4'(v_next >> 3) : '0;
        end
    end

    always_comb begin
        on_diff  = {1'b0, OFF_LEVEL} - {1'b0, lcd_contrast, 2'b00};
        on_level = on_diff[8] ? '0 : on_diff[7:0];

        pix_next        = '0;
        pix_next.de     = active;
        pix_next.hsync  = t_hsync;
        pix_next.vsync  = t_vsync;
        pix_next.hblank = t_hblank;
        pix_next.vblank = t_vblank;
        if (active)
            pix_next.luma = read_column[v[2:0]] ? on_level : OFF_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= ce_pix && (h == 8'd0) && (v == 7'd0);
            if (ce_pix)
                pix_q <= pix_next;
        end
    end

    assign luma        = pix_q.luma;
    assign de          = pix_q.de;
    assign hsync       = pix_q.hsync;
    assign vsync       = pix_q.vsync;
    assign hblank      = pix_q.hblank;
    assign vblank      = pix_q.vblank;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout: behavioural RAM with 1-clk latency and a raster model.
module tb_lcd_scanout;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ce_pix = 1'b0;
    logic [5:0] lcd_contrast = '0;
    logic [7:0] read_x;
    logic [3:0] read_y;
    logic [7:0] read_column = '0;
    logic [7:0] luma;
    logic       de, hsync, vsync, hblank, vblank, frame_start;

    lcd_scanout dut (
        .clk          (clk),
        .reset        (reset),
        .ce_pix       (ce_pix),
        .lcd_contrast (lcd_contrast),
        .read_x       (read_x),
        .read_y       (read_y),
        .read_column  (read_column),
        .luma         (luma),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .hblank       (hblank),
        .vblank       (vblank),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:7][0:95];

    always @(posedge clk)
        read_column <= (read_x < 8'd96 && read_y < 4'd8) ? ram[read_y[2:0]][read_x] : 8'hxx;

    localparam int FRAME = 128 * 80;
    int gaps [8] = '{2, 5, 3, 7, 4, 2, 6, 3};

    int checks = 0;
    int failures = 0;
    int pos = 0;

    int mism, de_cnt, fs_cnt, hs_cnt, vs_cnt, addr_mism, hold_mism, lit_cnt;
    logic [7:0] luma_5_0, luma_10_63;
    string first_mism;

    task automatic clear_ram();
        for (int p = 0; p < 8; p++)
            for (int c = 0; c < 96; c++)
                ram[p][c] = 8'h00;
    endtask

    task automatic clear_stats();
        mism = 0; de_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        addr_mism = 0; hold_mism = 0; lit_cnt = 0;
        luma_5_0 = 8'hxx; luma_10_63 = 8'hxx;
        first_mism = "none";
    endtask

    function automatic logic [7:0] model_luma(int h, int v);
        int c4;
        logic [7:0] on, byte_v;
        if (!(h < 96 && v < 64)) return 8'h00;
        c4 = int'(lcd_contrast) * 4;
        on = (c4 > 208) ? 8'h00 : 8'(208 - c4);
        byte_v = ram[v / 8][h];
        return byte_v[v % 8] ? on : 8'hD0;
    endfunction

    // One ce per pixel with the given spacing; compares every output against the raster model.
    task automatic scan(input int n, input bit irregular);
        int gap, h, v, nh, nv;
        logic [7:0] e_luma, e_rx, e_ry;
        logic e_de, e_hs, e_vs, e_hb, e_vb, e_fs;
        logic [15:0] snap;
        for (int i = 0; i < n; i++) begin
            gap = irregular ? gaps[i % 8] : 2;
            ce_pix = 1'b1;
            @(posedge clk); #1;
            ce_pix = 1'b0;
            h = (pos % FRAME) % 128;
            v = (pos % FRAME) / 128;
            e_de = (h < 96) && (v < 64);
            e_hs = (h >= 104) && (h < 112);
            e_vs = (v >= 68) && (v < 72);
            e_hb = (h >= 96);
            e_vb = (v >= 64);
            e_fs = (pos % FRAME) == 0;
            e_luma = model_luma(h, v);
            if (luma !== e_luma || de !== e_de || hsync !== e_hs || vsync !== e_vs ||
                hblank !== e_hb || vblank !== e_vb || frame_start !== e_fs) begin
                if (mism == 0)
                    first_mism = $sformatf("pix(%0d,%0d) luma=%h/%h de=%b/%b hs=%b/%b vs=%b/%b hb=%b/%b vb=%b/%b fs=%b/%b",
                        h, v, luma, e_luma, de, e_de, hsync, e_hs, vsync, e_vs, hblank, e_hb, vblank, e_vb, frame_start, e_fs);
                mism++;
            end
            if (de === 1'b1) de_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
            if (hsync === 1'b1) hs_cnt++;
            if (vsync === 1'b1) vs_cnt++;
            if (de === 1'b1 && luma !== 8'hD0) lit_cnt++;
            if (h == 5 && v == 0) luma_5_0 = luma;
            if (h == 10 && v == 63) luma_10_63 = luma;
            pos++;
            nh = (pos % FRAME) % 128;
            nv = (pos % FRAME) / 128;
            e_rx = (nh < 96 && nv < 64) ? 8'(nh) : 8'h00;
            e_ry = (nh < 96 && nv < 64) ? 8'(nv / 8) : 8'h00;
            if (read_x !== e_rx || {4'h0, read_y} !== e_ry) addr_mism++;
            snap = {luma, de, hsync, vsync, hblank, vblank, 3'b000};
            for (int k = 1; k < gap; k++) begin
                @(posedge clk); #1;
                if ({luma, de, hsync, vsync, hblank, vblank, 3'b000} !== snap || frame_start !== 1'b0)
                    hold_mism++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (luma !== 8'h00) begin
            failures++; $display("FAIL reset_luma: got %h expected 00", luma);
        end
        checks++;
        if ({de, hsync, vsync, hblank, vblank, frame_start} !== 6'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 000000", {de, hsync, vsync, hblank, vblank, frame_start});
        end
        checks++;
        if (read_x !== 8'h00 || read_y !== 4'h0) begin
            failures++; $display("FAIL reset_addr: got x=%h y=%h expected 00/0", read_x, read_y);
        end
        reset = 1'b0;
        pos = 0;
    endtask

    task automatic test_timing();
        clear_ram();
        ram[0][5] = 8'h01;
        lcd_contrast = 6'h00;
        clear_stats();
        scan(FRAME, 1'b0);
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL frame1_pixels: %0d mismatches, expected 0; first %s", mism, first_mism); end
        checks++;
        if (de_cnt !== 6144) begin failures++; $display("FAIL frame1_de_count: got %0d expected 6144", de_cnt); end
        checks++;
        if (fs_cnt !== 1) begin failures++; $display("FAIL frame1_fs_count: got %0d expected 1", fs_cnt); end
        checks++;
        if (hs_cnt !== 640) begin failures++; $display("FAIL frame1_hsync_count: got %0d expected 640", hs_cnt); end
        checks++;
        if (vs_cnt !== 512) begin failures++; $display("FAIL frame1_vsync_count: got %0d expected 512", vs_cnt); end
        checks++;
        if (addr_mism !== 0) begin failures++; $display("FAIL frame1_addr: %0d mismatches expected 0", addr_mism); end
        checks++;
        if (hold_mism !== 0) begin failures++; $display("FAIL frame1_hold: %0d changes between ce expected 0", hold_mism); end
        checks++;
        if (luma_5_0 !== 8'hD0) begin failures++; $display("FAIL c00_pixel_5_0: got %h expected d0", luma_5_0); end

        lcd_contrast = 6'h20;
        clear_stats();
        scan(FRAME, 1'b0);
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL frame2_pixels: %0d mismatches, expected 0; first %s", mism, first_mism); end
        checks++;
        if (de_cnt !== 6144 || fs_cnt !== 1) begin failures++; $display("FAIL frame2_counts: de=%0d fs=%0d expected 6144/1", de_cnt, fs_cnt); end
        checks++;
        if (luma_5_0 !== 8'h50) begin failures++; $display("FAIL c20_pixel_5_0: got %h expected 50", luma_5_0); end
        checks++;
        if (lit_cnt !== 1) begin failures++; $display("FAIL c20_lit_count: got %0d expected 1", lit_cnt); end
    endtask

    task automatic test_row_select();
        clear_ram();
        ram[7][10] = 8'h80;
        lcd_contrast = 6'h3F;
        clear_stats();
        scan(FRAME, 1'b0);
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL row_pixels: %0d mismatches, expected 0; first %s", mism, first_mism); end
        checks++;
        if (luma_10_63 !== 8'h00) begin failures++; $display("FAIL row_pixel_10_63: got %h expected 00", luma_10_63); end
        checks++;
        if (lit_cnt !== 1) begin failures++; $display("FAIL row_lit_count: got %0d expected 1", lit_cnt); end
        checks++;
        if (addr_mism !== 0) begin failures++; $display("FAIL row_addr: %0d mismatches expected 0", addr_mism); end
    endtask

    task automatic test_ce_gaps();
        ram[0][5] = 8'h01;
        ram[2][40] = 8'hFF;
        lcd_contrast = 6'h20;
        clear_stats();
        scan(20 * 128 + 40, 1'b1);
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL gaps_pixels: %0d mismatches, expected 0; first %s", mism, first_mism); end
        checks++;
        if (hold_mism !== 0) begin failures++; $display("FAIL gaps_hold: %0d changes between ce expected 0", hold_mism); end
        checks++;
        if (addr_mism !== 0 || fs_cnt !== 1) begin failures++; $display("FAIL gaps_addr_fs: addr_mism=%0d fs=%0d expected 0/1", addr_mism, fs_cnt); end
    endtask

    task automatic test_reset_midline();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({luma, de, hsync, vsync, hblank, vblank, frame_start} !== 14'b0) begin
            failures++; $display("FAIL midreset_outputs: got luma=%h flags=%b expected 00/000000", luma, {de, hsync, vsync, hblank, vblank, frame_start});
        end
        checks++;
        if (read_x !== 8'h00 || read_y !== 4'h0) begin
            failures++; $display("FAIL midreset_addr: got x=%h y=%h expected 00/0", read_x, read_y);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pos = 0;
        clear_stats();
        scan(1, 1'b0);
        checks++;
        if (fs_cnt !== 1 || mism !== 0) begin failures++; $display("FAIL midreset_first_pixel: fs=%0d mism=%0d expected 1/0; %s", fs_cnt, mism, first_mism); end
        clear_stats();
        scan(300, 1'b0);
        checks++;
        if (mism !== 0 || addr_mism !== 0) begin failures++; $display("FAIL midreset_restart: mism=%0d addr=%0d expected 0/0; %s", mism, addr_mism, first_mism); end
    endtask

    initial begin
        clear_ram();
        @(posedge clk); #1;
        test_reset();
        test_timing();
        test_row_select();
        test_ce_gaps();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Downstream consumer of the LCD controller's display-RAM read port; converts its column-organised framebuffer (pages of 8-pixel vertical bytes) into a raster pixel stream.
- Generates horizontal/vertical video timing and walks read_x/read_y across the 96x64 active area.
- Extracts one bit per pixel and maps it to an 8-bit grey level using the controller's contrast value.
- Output feeds the scaler/video mixer.

Parameters:
- H_ACTIVE, 96, active pixels per line
- H_FP, 8, front porch (pixels)
- H_SYNC, 8, hsync width (pixels)
- H_BP, 16, back porch (pixels); H_TOTAL = 128
- V_ACTIVE, 64, active lines
- V_FP, 4, front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 8, back porch (lines); V_TOTAL = 80
- OFF_LEVEL, 8'hD0, grey level of an unlit pixel

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- ce_pix  in  1  pixel clock enable; never asserted on two consecutive clk cycles
- lcd_contrast  in  6  contrast from the LCD controller
- read_x  out  8  display-RAM column address (0..95)
- read_y  out  4  display-RAM page address (0..7)
- read_column  in  8  RAM byte; valid 1 clk after read_x/read_y change
- luma  out  8  pixel grey level
- de  out  1  active-video qualifier
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- hblank  out  1  ~de horizontally
- vblank  out  1  vertical blanking
- frame_start  out  1  one-clk pulse with first active pixel (0,0)

Behaviour:
- Position counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance only on ce_pix. h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
- Active region is h<H_ACTIVE, v<V_ACTIVE. Horizontal order: active, FP, sync, BP. hsync=1 for h in [104,112). vsync=1 for v in [68,72), whole lines.
- Fetch: read_x/read_y are registered.
  - In the active region: read_x = h, read_y = v[5:3].
  - Outside the active region: both held at 0.
  - Updated on the same ce_pix that updates h/v, so read_column is stable from 1 clk after that ce until the next ce (guaranteed by ce_pix spacing).
- Output stage, registered on ce_pix, one pixel behind the counters:
  - Capture bit = read_column[v_prev[2:0]]; bit 0 is the top row of the page.
  - de, hsync, hblank, vblank are delayed one ce to stay aligned with luma.
- Grey mapping:
  - on_level = OFF_LEVEL − min(OFF_LEVEL, {contrast,2'b00}), computed at 9-bit width and saturating at 0.
  - luma = bit ? on_level : OFF_LEVEL when de; luma = 0 when !de.
  - lcd_contrast is sampled per pixel; mid-frame changes take effect from the next pixel.
- frame_start: 1 for exactly one clk, on the ce at which the output stage presents (0,0).
- Reset (synchronous, overrides ce_pix):
  - h = v = 0; read_x = read_y = 0.
  - luma = 0; de = hsync = vsync = hblank = vblank = frame_start = 0.
  - First ce after reset release begins the frame at (0,0). Reset mid-line aborts immediately, with no partial pixel output.
- ce_pix low: all state holds; outputs stay constant.

Decomposition:
- Shared package pm_video_pkg:
  - timing default constants (H_*/V_*);
  - pixel record typedef {luma, de, hsync, vsync, hblank, vblank}.
- One sub-module, pm_video_timing: h/v counters plus sync/blank/active decode, reusable by other video stages.
- The fetch/pixel pipeline stays in lcd_scanout.

Test Plan:
- Timing: ce_pix every 2nd clk for 2 frames -> 80 lines x 128 ce per frame; de count = 6144 per frame; hsync high 8 ce at h 104..111; vsync high lines 68..71; frame_start exactly once per frame.
- Bit mapping: RAM model returns 8'h01 for page 0 column 5, 0 elsewhere; contrast=0 -> pixel (5,0) luma=8'hD0 (on_level = D0); contrast=6'h20 -> (5,0) luma=8'h50, all other active pixels 8'hD0.
- Row select: column 10 page 7 = 8'h80 -> only pixel (10,63) lit; contrast=6'h3F -> on_level = 8'hD0−8'hFC saturates to 8'h00.
- Address/latency: check read_x/read_y equal (h, v>>3) one ce before each active pixel; RAM model with 1-clk latency yields no pixel shift; read_x=read_y=0 throughout blanking.
- Reset mid-line: assert reset at (40,20) for 3 clks -> all outputs 0 next clk; after release first active output is (0,0) with frame_start pulse.
- ce gaps: irregular ce_pix spacing (2..7 clks) -> identical pixel sequence to the regular case; outputs constant between ce.
